cpu_run_ctrl: RTL and testbench

Run/step/breakpoint sequencer for the single-cycle RV core. It owns the core's reset and a per-cycle execute enable (cpu_en), which the top level ANDs into PC update, RegWrite and MemWrite. It takes the operator run switch and step button from ui_in, plus the current PC. It also provides a retired-instruction counter for debug display.

---
 rtl/cpu_run_ctrl.sv | 110 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint sequencer owning core reset and per-cycle execute enable.
// Breakpoint logic is built only when RUNCTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl #(
   parameter int PC_W        = 5,
   parameter int DEB_CYCLES  = 16,
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_sw,
   input  logic             step_btn,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  pc,
   output logic             cpu_rst,
   output logic             cpu_en,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] instret
);
   typedef enum logic [2:0] {HOLD = 3'd0, HALT = 3'd1, RUN = 3'd2, STEP = 3'd3, BREAK = 3'd4} state_t;
   localparam int DW = $clog2(DEB_CYCLES);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

   state_t           state_q;
   logic             cpu_rst_q;
   logic [HW-1:0]    hold_q;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [1:0]       sync1_q, sync2_q, deb_q;
   logic [DW-1:0]    cnt_q [2];
   logic             step_prev_q;
   logic             run_lvl, step_pulse, bp_hit;

   // bit 0 = run switch, bit 1 = step button
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         deb_q       <= '0;
         step_prev_q <= 1'b0;
         cnt_q       <= '{default: '0};
      end else begin
         sync1_q     <= {step_btn, run_sw};
         sync2_q     <= sync1_q;
         step_prev_q <= deb_q[1];
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) cnt_q[i] <= '0;
            else if (cnt_q[i] == DEB_MAX) begin
               cnt_q[i] <= '0;
               deb_q[i] <= ~deb_q[i];
            end else cnt_q[i] <= cnt_q[i] + DW'(1);
         end
      end
   end

   assign run_lvl    = deb_q[0];
   assign step_pulse = deb_q[1] & ~step_prev_q;

`ifdef RUNCTRL_BREAKPOINT_EN
   logic skip_q;
   assign bp_hit = bp_en && (pc == bp_addr) && !skip_q;
   // skip lets the instruction sitting on the breakpoint execute once after a resume
   always_ff @(posedge clk) begin
      if (reset) skip_q <= 1'b0;
      else if (state_q == HALT && run_lvl) skip_q <= 1'b1;
      else if (state_q == RUN && cpu_en) skip_q <= 1'b0;
   end
`else
   logic unused_bp;
   assign unused_bp = ^{bp_en, bp_addr, pc};
   assign bp_hit    = 1'b0;
`endif

   assign cpu_en = (state_q == RUN) ? (run_lvl & ~bp_hit) : (state_q == STEP);

   always_comb instret_d = (cpu_en && !(&instret_q)) ? instret_q + CNT_W'(1) : instret_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= HOLD;
         cpu_rst_q <= 1'b1;
         hold_q    <= '0;
         instret_q <= '0;
      end else begin
         instret_q <= instret_d;
         case (state_q)
            HOLD: begin
               if (hold_q == HOLD_MAX) begin
                  state_q   <= HALT;
                  cpu_rst_q <= 1'b0;
               end else hold_q <= hold_q + HW'(1);
            end
            HALT:    state_q <= run_lvl ? RUN : (step_pulse ? STEP : HALT);
            RUN:     state_q <= !run_lvl ? HALT : (bp_hit ? BREAK : RUN);
            STEP:    state_q <= HALT;
            BREAK:   state_q <= !run_lvl ? HALT : (step_pulse ? STEP : BREAK);
            default: begin
               state_q   <= HALT;
               cpu_rst_q <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_rst = cpu_rst_q;
   assign state_o = state_q;
   assign instret = instret_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scoreboard bench for cpu_run_ctrl (reset, debounce, run, breakpoint, step, mid-run reset).
module tb_cpu_run_ctrl;
   logic        clk = 1'b0;
   logic        reset, run_sw, step_btn, bp_en;
   logic [4:0]  bp_addr, pc;
   logic        cpu_rst, cpu_en;
   logic [2:0]  state_o;
   logic [15:0] instret;
   int          checks = 0, errors = 0;
   int          en_cnt = 0, st3_cnt = 0;
   int          n, e0, s0, base;

   typedef struct {string tag; int unsigned v;} exp_t;
   exp_t sb[$];

   cpu_run_ctrl dut (
      .clk(clk), .reset(reset), .run_sw(run_sw), .step_btn(step_btn),
      .bp_addr(bp_addr), .bp_en(bp_en), .pc(pc),
      .cpu_rst(cpu_rst), .cpu_en(cpu_en), .state_o(state_o), .instret(instret)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cpu_en) en_cnt++;
      if (state_o == 3'd3) st3_cnt++;
   end

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input int unsigned v);
      sb.push_back('{tag, v});
   endtask

   task automatic pop_chk(input int unsigned got);
      exp_t e;
      chk("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, got, e.v);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int bound);
      n = 0;
      while (state_o != s && n < bound) begin
         cyc(1);
         n++;
      end
   endtask

   initial begin
      reset = 1'b1; run_sw = 1'b0; step_btn = 1'b0; bp_en = 1'b0; bp_addr = 5'd0; pc = 5'd0;
      cyc(3);
      chk("rst_state", state_o, 0);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_cpu_en", cpu_en, 0);
      chk("rst_instret", instret, 0);
      push("hold_len", 4);
      reset = 1'b0;
      n = 0;
      while (cpu_rst && n < 20) begin
         if (cpu_en || state_o != 3'd0) chk("hold_quiet", {cpu_en, state_o}, 0);
         n++;
         cyc(1);
      end
      pop_chk(n);
      chk("halt_after_hold", state_o, 1);

      e0 = en_cnt;
      step_btn = 1'b1; cyc(10); step_btn = 1'b0; cyc(40);
      chk("glitch_no_en", en_cnt - e0, 0);
      chk("glitch_state", state_o, 1);

      e0 = en_cnt; s0 = st3_cnt;
      push("step_en_cycles", 1); push("step_state_cycles", 1); push("step_instret", 1);
      step_btn = 1'b1; cyc(30); step_btn = 1'b0; cyc(40);
      pop_chk(en_cnt - e0);
      pop_chk(st3_cnt - s0);
      pop_chk(instret);
      chk("step_back_halt", state_o, 1);

      push("run_latency", 19); push("run_entry_instret", 1); push("run_count", 21);
      run_sw = 1'b1;
      wait_state(3'd2, 40);
      pop_chk(n);
      pop_chk(instret);
      repeat (20) begin cyc(1); pc = pc + 1'b1; end
      pop_chk(instret);
      push("run_off_instret", 39); push("run_frozen", 39);
      run_sw = 1'b0;
      cyc(40);
      pop_chk(instret);
      chk("run_off_state", state_o, 1);
      cyc(10);
      pop_chk(instret);

      bp_en = 1'b1; bp_addr = 5'd5; pc = 5'd0;
      run_sw = 1'b1;
      wait_state(3'd2, 40);
      chk("bp_run_entry", state_o, 2);
      base = instret;
`ifdef RUNCTRL_BREAKPOINT_EN
      push("bp_instret", base + 5);
      for (int i = 1; i <= 5; i++) begin cyc(1); pc = 5'(i); end
      #2;
      chk("bp_en_low", cpu_en, 0);
      cyc(1);
      chk("bp_break_state", state_o, 4);
      pop_chk(instret);

      run_sw = 1'b0;
      wait_state(3'd1, 40);
      chk("resume_halt", state_o, 1);
      run_sw = 1'b1;
      wait_state(3'd2, 40);
      chk("resume_run", state_o, 2);
      chk("resume_skip_en", cpu_en, 1);
      base = instret;
      push("resume_once", base + 1); push("rebreak_instret", base + 32);
      cyc(1); pc = 5'd6; #2;
      chk("resume_en_next", cpu_en, 1);
      pop_chk(instret);
      for (int k = 0; k < 31; k++) begin cyc(1); pc = pc + 1'b1; end
      #2;
      chk("rebreak_en_low", cpu_en, 0);
      cyc(1);
      chk("rebreak_state", state_o, 4);
      pop_chk(instret);

      step_btn = 1'b1;
      wait_state(3'd3, 40);
      chk("brk_step_state", state_o, 3);
      chk("brk_step_en", cpu_en, 1);
      step_btn = 1'b0;
      cyc(1);
      chk("brk_step_halt", state_o, 1);
      bp_en = 1'b0;
`else
      push("nobp_instret", base + 10);
      for (int i = 1; i <= 9; i++) begin
         cyc(1); pc = 5'(i);
         if (i == 5) begin
            #2;
            chk("nobp_en_at_match", cpu_en, 1);
         end
      end
      cyc(1);
      pop_chk(instret);
      chk("nobp_state", state_o, 2);
      run_sw = 1'b0;
      wait_state(3'd1, 40);
      chk("nobp_halt", state_o, 1);
      bp_en = 1'b0;
      run_sw = 1'b1;
`endif

      wait_state(3'd2, 40);
      chk("mid_run_state", state_o, 2);
      push("mid_instret", 100);
      n = 0;
      while (instret != 16'd100 && n < 200) begin cyc(1); pc = pc + 1'b1; n++; end
      pop_chk(instret);
      reset = 1'b1;
      cyc(1);
      chk("mid_rst_state", state_o, 0);
      chk("mid_rst_cpu_rst", cpu_rst, 1);
      chk("mid_rst_instret", instret, 0);
      chk("mid_rst_en", cpu_en, 0);
      reset = 1'b0; run_sw = 1'b0;
      cyc(5);
      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
